difftest_snapshot_csr_source: RTL

//  Producer side of the difftest CSR-snapshot channel. Owns the architectural mcycle/minstret

---
 rtl/difftest_snapshot_csr_source.sv | 90 +++++++++
 1 files changed

// File: rtl/difftest_snapshot_csr_source.sv
// Producer of {minstret, mcycle, coreid} snapshots for the difftest CSR channel.
// Owns the mcycle/minstret counters, a period timer, and a one-deep trigger backlog.
module difftest_snapshot_csr_source #(
    parameter int COMMIT_WIDTH = 4,
    parameter int PERIOD_W     = 16,
    localparam int CNT_W       = $clog2(COMMIT_WIDTH + 1)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [7:0]          io_coreid,
    input  logic [CNT_W-1:0]    io_commit_cnt,
    input  logic                io_csr_wen,
    input  logic                io_csr_sel,
    input  logic [63:0]         io_csr_wdata,
    input  logic [PERIOD_W-1:0] io_period,
    input  logic                io_snap_req,
    output logic                io_snap_valid,
    input  logic                io_snap_ready,
    output logic [63:0]         io_minstret,
    output logic [63:0]         io_mcycle,
    output logic [7:0]          io_coreid_out,
    output logic [15:0]         io_dropped
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t              state;
    logic [63:0]         mcycle, minstret;
    logic [PERIOD_W-1:0] tmr;
    logic                pending;
    logic [CNT_W-1:0]    cnt_clamped;
    logic                timer_event, trig;

    assign cnt_clamped = (io_commit_cnt > CNT_W'(COMMIT_WIDTH)) ? CNT_W'(COMMIT_WIDTH) : io_commit_cnt;
    assign timer_event = (io_period != '0) && (tmr >= io_period - PERIOD_W'(1));
    assign trig        = timer_event | io_snap_req;

    // A CSR write replaces that counter's increment for the cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcycle   <= '0;
            minstret <= '0;
            tmr      <= '0;
        end else begin
            mcycle   <= (io_csr_wen && !io_csr_sel) ? io_csr_wdata : mcycle + 64'd1;
            minstret <= (io_csr_wen &&  io_csr_sel) ? io_csr_wdata : minstret + 64'(cnt_clamped);
            if (io_period == '0 || timer_event) tmr <= '0;
            else                                tmr <= tmr + PERIOD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pending       <= 1'b0;
            io_snap_valid <= 1'b0;
            io_minstret   <= '0;
            io_mcycle     <= '0;
            io_coreid_out <= '0;
            io_dropped    <= '0;
        end else begin
            case (state)
                IDLE: if (trig) begin
                    io_minstret   <= minstret;
                    io_mcycle     <= mcycle;
                    io_coreid_out <= io_coreid;
                    io_snap_valid <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (io_snap_ready) begin
                        if (pending || trig) begin
                            // Back-to-back: a new capture replaces the one just accepted.
                            io_minstret   <= minstret;
                            io_mcycle     <= mcycle;
                            io_coreid_out <= io_coreid;
                            pending       <= 1'b0;
                        end else begin
                            io_snap_valid <= 1'b0;
                            state         <= IDLE;
                        end
                    end else if (trig) begin
                        if (!pending)                  pending    <= 1'b1;
                        else if (io_dropped != '1)     io_dropped <= io_dropped + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
